keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Parametrised N_ROWS x N_COLS matrix keypad scanner. Successor to the fixed 4x4 single-clock scanner.
- Adds a configurable scan rate, a settle delay and frame-level debounce.
- Emits press/release event strobes and multi-key detection, with optional 7-segment encoding.
- Sits between the keypad GPIO header and the board's user logic and display drivers.

Parameters:
- N_ROWS, 4, number of row inputs (2..8)
- N_COLS, 4, number of column drives (2..8)
- COL_CYCLES, 50000, clocks per column slot (1 ms at 50 MHz); must be > SETTLE_CYCLES+2
- SETTLE_CYCLES, 8, clocks after column drive before rows are sampled
- DEBOUNCE_SCANS, 3, consecutive identical full frames required to commit a key state (1..15)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- row_i  in  N_ROWS  row lines, active-low (0 = pressed in the driven column); double-flop synchronised internally
- col_o  out  N_COLS  column drive, one-cold (exactly one bit 0 while scanning)
- key_code_o  out  KW=$clog2(N_ROWS*N_COLS)  index of committed key = row*N_COLS+col
- key_valid_o  out  1  high while exactly one debounced key is held
- key_press_o  out  1  one-cycle pulse when key_valid_o rises or key_code_o changes to a new single key
- key_release_o  out  1  one-cycle pulse when key_valid_o falls
- multi_key_o  out  1  high while the committed frame has >1 key pressed
- frame_done_o  out  1  one-cycle pulse at the end of every full scan

Behaviour:
- Reset (async assert, sync deassert internally): col_o = all 1s, key_code_o = 0, key_valid_o / key_press_o / key_release_o / multi_key_o / frame_done_o = 0, col index = 0, slot counter = 0, frame and committed bitmaps = 0, stable count = 0. FSM enters DRIVE on the first clock after release.
- FSM states: DRIVE, SAMPLE, HOLD, EVAL.
  - DRIVE: col_o bit[col] = 0, all other bits 1; the counter runs SETTLE_CYCLES clocks, then SAMPLE.
  - SAMPLE, one cycle: frame bitmap bits [r*N_COLS+col] = ~row_sync[r] for every r. Then HOLD.
  - HOLD: wait until the slot counter reaches COL_CYCLES-1.
    - If col < N_COLS-1: col++, go to DRIVE.
    - Otherwise go to EVAL.
  - EVAL, one cycle: pulse frame_done_o, apply the debounce step, col = 0, then DRIVE.
- Slot counter: reset to 0 on each DRIVE entry. Width is $clog2(COL_CYCLES).
- Debounce step:
  - If the new frame equals the previous frame: stable count increments, saturating at DEBOUNCE_SCANS.
  - Otherwise: stable count = 1 and the previous frame takes the new frame.
  - When the stable count first reaches DEBOUNCE_SCANS, the frame is committed.
- Commit outcomes:
  - popcount = 0: key_valid_o = 0, multi_key_o = 0; key_release_o pulses if key_valid_o was 1. key_code_o holds its last value.
  - popcount = 1: key_code_o = index of the set bit, key_valid_o = 1, multi_key_o = 0; key_press_o pulses if the key is new.
  - popcount > 1: multi_key_o = 1, key_valid_o = 0, key_code_o unchanged; key_release_o pulses if key_valid_o was 1. No press is reported until the frame resolves back to a single key.
- Commit latency: outputs update on the cycle after EVAL. Worst-case press-to-strobe latency is (DEBOUNCE_SCANS+1) x N_COLS x COL_CYCLES + 4 clocks.
- Press and release never pulse in the same cycle. Key A to key B with no empty frame between them gives a key_press_o for B only.
- Any reset mid-scan returns the block to the reset state, with no strobes emitted.

Optional Feature:
- Macro KEYPAD_SCANNER_SEG_EN adds output seg_o [15:0]: two active-low 7-seg digits (bit 7/15 = dp, always off).
- Digit content:
  - key_code_o 0..9 drive the low digit; the high digit is blank.
  - Codes 10..15 drive the high digit with glyphs A, b, C, d, E, F; the low digit is blank.
  - Codes above 15 (larger matrices) show "--".
- When key_valid_o = 0, seg_o = 16'hFFFF.
- seg_o is registered and changes in the same cycle as key_valid_o / key_code_o. Its reset value is 16'hFFFF.
- Without the macro the port and its logic are absent, and every other behaviour is identical.

Decomposition:
- Package keypad_pkg holds:
  - FSM state enum, state_t {DRIVE, SAMPLE, HOLD, EVAL}
  - the 7-seg glyph constants (SEG_0..SEG_F, SEG_BLANK, SEG_DASH)
  - the default 4x4 label map function, key_label(idx) -> 4-bit hex label
  - a popcount-saturate-to-2 function
- Sub-module: keypad_seg7_encode (combinational label -> seg pair, instantiated only under KEYPAD_SCANNER_SEG_EN).

Test Plan:
1. Reset, COL_CYCLES=20, SETTLE_CYCLES=4, DEBOUNCE_SCANS=3, no keys.
   - Required: col_o cycles 1110 -> 1101 -> 1011 -> 0111, 20 clocks each.
   - Required: frame_done_o every 81 clocks; all key outputs stay 0.
2. Hold row1/col2 (index 6) pressed.
   - Required: key_press_o pulses once after the 3rd identical frame; key_valid_o = 1, key_code_o = 6.
   - With KEYPAD_SCANNER_SEG_EN: seg_o = ~16'h007D.
3. Release index 6 after 5 frames.
   - Required: key_release_o pulses once, 3 frames later; key_valid_o = 0; key_code_o stays 6.
4. Toggle the index 6 row line every frame (bounce) for 6 frames, then hold it.
   - Required: no strobes during the bounce; one key_press_o only after 3 stable frames.
5. Press indices 0 and 15 together.
   - Required: multi_key_o = 1, key_valid_o = 0, no key_press_o.
   - Release index 15: after 3 frames multi_key_o = 0 and key_press_o fires with key_code_o = 0.
6. Assert rst_n low mid-DRIVE while key 6 is valid.
   - Required: outputs clear immediately, col_o = 1111, no release strobe; scanning restarts from col 0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner:
// FSM states, 7-seg glyphs, key label map and popcount.
package keypad_pkg;

  typedef enum logic [1:0] {
    DRIVE,
    SAMPLE,
    HOLD,
    EVAL
  } state_t;

  // Active-high gfedcba patterns; the encoder inverts them
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  function automatic logic [3:0] key_label(
    input logic [3:0] idx
  );
    return idx;
  endfunction

  function automatic logic [1:0] popcnt_sat2(
    input logic [63:0] v
  );
    logic [1:0] n;
    n = 2'd0;
    for (int i = 0; i < 64; i++) begin
      if (v[i] && n != 2'd2) n = n + 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/keypad_seg7_encode.sv
// Key code to two active-low 7-seg digits (dp off).
// Codes 0-9 on the low digit, A-F on the high digit, "--" above 15.
module keypad_seg7_encode
  import keypad_pkg::*;
#(
  parameter int KW = 4
) (
  input  logic [KW-1:0] code_i,
  output logic [15:0]   seg_o
);

  logic [7:0] code_w;
  logic [3:0] lbl;
  logic [6:0] glyph;
  logic [6:0] hi;
  logic [6:0] lo;

  always_comb begin
    code_w = 8'(code_i);
    lbl    = key_label(code_w[3:0]);
    unique case (lbl)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = SEG_A;
      4'hB: glyph = SEG_B;
      4'hC: glyph = SEG_C;
      4'hD: glyph = SEG_D;
      4'hE: glyph = SEG_E;
      4'hF: glyph = SEG_F;
    endcase
    hi = SEG_BLANK;
    lo = SEG_BLANK;
    if (code_w > 8'd15) begin
      hi = SEG_DASH;
      lo = SEG_DASH;
    end else if (lbl > 4'd9) begin
      hi = glyph;
    end else begin
      lo = glyph;
    end
    seg_o = ~{1'b0, hi, 1'b0, lo};
  end

endmodule

// File: rtl/keypad_scanner.sv
// Parametrised matrix keypad scanner with frame debounce and strobes.
// Define KEYPAD_SCANNER_SEG_EN to add the registered seg_o display port.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int N_ROWS         = 4,
  parameter int N_COLS         = 4,
  parameter int COL_CYCLES     = 50000,
  parameter int SETTLE_CYCLES  = 8,
  parameter int DEBOUNCE_SCANS = 3,
  localparam int NK            = N_ROWS * N_COLS,
  localparam int KW            = $clog2(NK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_ROWS-1:0] row_i,
  output logic [N_COLS-1:0] col_o,
  output logic [KW-1:0]     key_code_o,
  output logic              key_valid_o,
  output logic              key_press_o,
  output logic              key_release_o,
  output logic              multi_key_o,
  output logic              frame_done_o
`ifdef KEYPAD_SCANNER_SEG_EN
  ,
  output logic [15:0]       seg_o
`endif
);

  localparam int SCW = $clog2(COL_CYCLES);
  localparam int CIW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);
  localparam logic [N_COLS-1:0] COL0 = N_COLS'(1);

  logic [1:0]        rst_q;
  logic              rst_int_n;
  logic [N_ROWS-1:0] row_meta_q;
  logic [N_ROWS-1:0] row_sync_q;

  state_t            state_q;
  logic              run_q;
  logic [SCW-1:0]    cnt_q;
  logic [CIW-1:0]    col_q;
  logic [N_COLS-1:0] col_o_q;
  logic [NK-1:0]     frame_q;
  logic [NK-1:0]     frame_d;
  logic [NK-1:0]     prev_q;
  logic [NK-1:0]     committed_q;
  logic [3:0]        stable_q;
  logic [3:0]        stable_d;
  logic [KW-1:0]     code_q;
  logic              valid_q;
  logic              press_q;
  logic              release_q;
  logic              multi_q;
  logic              done_q;

  logic              same;
  logic              commit;
  logic [1:0]        pc;
  logic [KW-1:0]     idx;

  // Async assert, synchronous release of the internal reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 2'b00;
    else        rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_int_n = rst_q[1];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= row_i;
      row_sync_q <= row_meta_q;
    end
  end

  always_comb begin
    frame_d = frame_q;
    if (state_q == SAMPLE) begin
      for (int r = 0; r < N_ROWS; r++) begin
        for (int c = 0; c < N_COLS; c++) begin
          if (c == int'(col_q)) frame_d[r*N_COLS+c] = ~row_sync_q[r];
        end
      end
    end
  end

  always_comb begin
    pc  = popcnt_sat2(64'(frame_q));
    idx = '0;
    for (int i = 0; i < NK; i++) begin
      if (frame_q[i]) idx = KW'(i);
    end
    same = (frame_q == prev_q);
    if (!same)              stable_d = 4'd1;
    else if (stable_q == DEB) stable_d = stable_q;
    else                    stable_d = stable_q + 4'd1;
    // Commit only on the frame where the count first hits the target
    commit = (stable_d == DEB) && (!same || stable_q != DEB);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= DRIVE;
      run_q       <= 1'b0;
      cnt_q       <= '0;
      col_q       <= '0;
      col_o_q     <= '1;
      frame_q     <= '0;
      prev_q      <= '0;
      committed_q <= '0;
      stable_q    <= '0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      multi_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      done_q    <= 1'b0;
      frame_q   <= frame_d;
      if (!run_q) begin
        run_q   <= 1'b1;
        state_q <= DRIVE;
        cnt_q   <= '0;
        col_q   <= '0;
        col_o_q <= ~COL0;
      end else begin
        unique case (state_q)
          DRIVE: begin
            cnt_q <= cnt_q + SCW'(1);
            if (cnt_q == SCW'(SETTLE_CYCLES - 1)) state_q <= SAMPLE;
          end
          SAMPLE: begin
            cnt_q   <= cnt_q + SCW'(1);
            state_q <= HOLD;
          end
          HOLD: begin
            if (cnt_q == SCW'(COL_CYCLES - 1)) begin
              cnt_q <= '0;
              if (col_q == CIW'(N_COLS - 1)) begin
                state_q <= EVAL;
                col_o_q <= '1;
                done_q  <= 1'b1;
              end else begin
                state_q <= DRIVE;
                col_q   <= col_q + CIW'(1);
                col_o_q <= ~(COL0 << (col_q + CIW'(1)));
              end
            end else begin
              cnt_q <= cnt_q + SCW'(1);
            end
          end
          EVAL: begin
            state_q  <= DRIVE;
            cnt_q    <= '0;
            col_q    <= '0;
            col_o_q  <= ~COL0;
            stable_q <= stable_d;
            if (!same) prev_q <= frame_q;
            if (commit) begin
              committed_q <= frame_q;
              unique case (pc)
                2'd0: begin
                  valid_q   <= 1'b0;
                  multi_q   <= 1'b0;
                  release_q <= valid_q;
                end
                2'd1: begin
                  code_q  <= idx;
                  valid_q <= 1'b1;
                  multi_q <= 1'b0;
                  press_q <= !valid_q || (committed_q != frame_q);
                end
                default: begin
                  multi_q   <= 1'b1;
                  valid_q   <= 1'b0;
                  release_q <= valid_q;
                end
              endcase
            end
          end
        endcase
      end
    end
  end

  assign col_o         = col_o_q;
  assign key_code_o    = code_q;
  assign key_valid_o   = valid_q;
  assign key_press_o   = press_q;
  assign key_release_o = release_q;
  assign multi_key_o   = multi_q;
  assign frame_done_o  = done_q;

`ifdef KEYPAD_SCANNER_SEG_EN
  logic [15:0] seg_q;
  logic [15:0] seg_w;

  keypad_seg7_encode #(
    .KW(KW)
  ) u_seg (
    .code_i(idx),
    .seg_o (seg_w)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      seg_q <= 16'hFFFF;
    end else if (run_q && state_q == EVAL && commit) begin
      seg_q <= (pc == 2'd1) ? seg_w : 16'hFFFF;
    end
  end

  assign seg_o = seg_q;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: scan timing, debounce,
// strobes, multi-key and mid-scan reset on a 4x4 matrix.
module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] key_code_o;
  logic       key_valid_o;
  logic       key_press_o;
  logic       key_release_o;
  logic       multi_key_o;
  logic       frame_done_o;
`ifdef KEYPAD_SCANNER_SEG_EN
  logic [15:0] seg_o;
`endif

  logic [15:0] pressed;
  int errors;
  int checks;
  int n_press;
  int n_rel;
  int n_both;
  int p0;
  int r0;

  keypad_scanner #(
    .N_ROWS        (4),
    .N_COLS        (4),
    .COL_CYCLES    (20),
    .SETTLE_CYCLES (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .row_i        (row_i),
    .col_o        (col_o),
    .key_code_o   (key_code_o),
    .key_valid_o  (key_valid_o),
    .key_press_o  (key_press_o),
    .key_release_o(key_release_o),
    .multi_key_o  (multi_key_o),
    .frame_done_o (frame_done_o)
`ifdef KEYPAD_SCANNER_SEG_EN
    ,
    .seg_o        (seg_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive keypad: a held key pulls its row low when its column is driven
  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (key_press_o) n_press++;
      if (key_release_o) n_rel++;
      if (key_press_o && key_release_o) n_both++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_fd(input int n);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < n * 100 + 200) begin
      @(negedge clk);
      cyc++;
      if (frame_done_o) got++;
    end
    if (got < n) chk("fd_timeout", got, n);
  endtask

  task automatic wait_col(input logic [3:0] pat);
    int n;
    n = 0;
    while (col_o !== pat && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (col_o !== pat) chk("col_timeout", col_o, pat);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    n_press = 0;
    n_rel   = 0;
    n_both  = 0;
    pressed = '0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_col", col_o, 4'hF);
    chk("rst_code", key_code_o, 0);
    chk("rst_valid", key_valid_o, 0);
    chk("rst_press", key_press_o, 0);
    chk("rst_rel", key_release_o, 0);
    chk("rst_multi", multi_key_o, 0);
    chk("rst_fd", frame_done_o, 0);
    rst_n = 1'b1;

    // 1: column sequence and frame period
    wait_col(4'b1110);
    for (int k = 1; k <= 161; k++) begin
      @(negedge clk);
      if (k == 19) chk("col0_len", col_o, 4'b1110);
      if (k == 20) chk("col1", col_o, 4'b1101);
      if (k == 40) chk("col2", col_o, 4'b1011);
      if (k == 60) chk("col3", col_o, 4'b0111);
      if (k == 80) chk("eval_fd", frame_done_o, 1);
      if (k == 81) chk("wrap_col0", col_o, 4'b1110);
      if (k == 160) chk("fd_gap", frame_done_o, 0);
      if (k == 161) chk("fd_period", frame_done_o, 1);
    end
    wait_fd(2);
    chk("idle_press", n_press, 0);
    chk("idle_rel", n_rel, 0);
    chk("idle_valid", key_valid_o, 0);
    chk("idle_multi", multi_key_o, 0);

    // 2: hold index 6
    pressed[6] = 1'b1;
    wait_fd(2);
    chk("early_press", n_press, 0);
    wait_fd(1);
    @(negedge clk);
    chk("k6_press", key_press_o, 1);
    chk("k6_valid", key_valid_o, 1);
    chk("k6_code", key_code_o, 6);
`ifdef KEYPAD_SCANNER_SEG_EN
    chk("k6_seg", seg_o, 16'hFF82);
`endif
    @(negedge clk);
    chk("k6_pulse1", key_press_o, 0);

    // 3: release after 5 frames
    wait_fd(2);
    pressed[6] = 1'b0;
    wait_fd(2);
    chk("rel_early_valid", key_valid_o, 1);
    chk("rel_early_cnt", n_rel, 0);
    wait_fd(1);
    @(negedge clk);
    chk("k6_rel", key_release_o, 1);
    chk("k6_rel_valid", key_valid_o, 0);
    chk("k6_rel_code", key_code_o, 6);
`ifdef KEYPAD_SCANNER_SEG_EN
    chk("rel_seg", seg_o, 16'hFFFF);
`endif

    // 4: bounce for 6 frames, then hold
    wait_fd(1);
    p0 = n_press;
    r0 = n_rel;
    for (int i = 0; i < 6; i++) begin
      pressed[6] = (i % 2 == 0);
      wait_fd(1);
    end
    pressed[6] = 1'b1;
    wait_fd(2);
    chk("bounce_press", n_press, p0);
    chk("bounce_rel", n_rel, r0);
    wait_fd(1);
    @(negedge clk);
    chk("settled_press", key_press_o, 1);
    chk("settled_code", key_code_o, 6);

    // 5: two keys, then resolve to index 0
    wait_fd(1);
    pressed = '0;
    wait_fd(3);
    @(negedge clk);
    chk("pre_multi_rel", key_release_o, 1);
    wait_fd(1);
    pressed = 16'h8001;
    p0 = n_press;
    wait_fd(3);
    @(negedge clk);
    chk("multi_on", multi_key_o, 1);
    chk("multi_valid", key_valid_o, 0);
    chk("multi_code", key_code_o, 6);
    chk("multi_norel", key_release_o, 0);
    wait_fd(1);
    pressed[15] = 1'b0;
    wait_fd(2);
    chk("multi_nopress", n_press, p0);
    wait_fd(1);
    @(negedge clk);
    chk("multi_off", multi_key_o, 0);
    chk("k0_press", key_press_o, 1);
    chk("k0_code", key_code_o, 0);
    chk("k0_valid", key_valid_o, 1);
`ifdef KEYPAD_SCANNER_SEG_EN
    chk("k0_seg", seg_o, 16'hFFC0);
`endif

    // 6: key 0 straight to key 6, then reset mid-DRIVE
    wait_fd(1);
    pressed = 16'h0040;
    r0 = n_rel;
    wait_fd(3);
    @(negedge clk);
    chk("ab_press", key_press_o, 1);
    chk("ab_code", key_code_o, 6);
    chk("ab_norel", key_release_o, 0);
    wait_fd(1);
    chk("ab_relcnt", n_rel, r0);
    wait_col(4'b1101);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_col", col_o, 4'hF);
    chk("mid_rst_valid", key_valid_o, 0);
    chk("mid_rst_code", key_code_o, 0);
    chk("mid_rst_rel", key_release_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    r0 = n_rel;
    wait_col(4'b1110);
    chk("restart_col0", col_o, 4'b1110);
    repeat (5) @(negedge clk);
    chk("restart_norel", n_rel, r0);
    chk("no_overlap", n_both, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
